// File: rtl/up_counter_pkg.sv
// up_counter_pkg: shared defaults for the up_counter family.
package up_counter_pkg;
    localparam int DEFAULT_WIDTH = 4;
    function automatic longint unsigned default_max(input int width);
        return (64'd1 << width) - 64'd1;
    endfunction
endpackage

// File: rtl/up_counter_core.sv
// up_counter_core: WIDTH-bit register with async reset to RESET_VAL.
module up_counter_core
    import up_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] next,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= RESET_VAL;
        else q <= next;
    end
endmodule

// File: rtl/up_counter.sv
// up_counter: free-running modulo MAX_VAL+1 counter with terminal count and wrap pulse.
module up_counter
    import up_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter longint unsigned MAX_VAL = default_max(WIDTH),
    parameter longint unsigned RESET_VAL = 0
)(
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
    logic [WIDTH-1:0] next;
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("up_counter: WIDTH out of range 1..32");
    end
    if (MAX_VAL > default_max(WIDTH)) begin : g_bad_max
        $error("up_counter: MAX_VAL does not fit in WIDTH bits");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("up_counter: RESET_VAL exceeds MAX_VAL");
    end
    assign tc = count == MAX_W;
    assign next = tc ? '0 : count + WIDTH'(1);
    // wrap lines up with the cycle in which count reads 0 after leaving MAX_VAL
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wrap <= 1'b0;
        else wrap <= tc;
    end
    up_counter_core #(.WIDTH(WIDTH), .RESET_VAL(RESET_W)) u_core (
        .clk  (clk),
        .reset(reset),
        .next (next),
        .q    (count)
    );
endmodule

// File: tb/tb_up_counter.sv
// tb_up_counter: scoreboard bench for default and MAX_VAL=9/RESET_VAL=3 counters.
module tb_up_counter;
    typedef struct {
        logic [3:0] c0;
        logic       t0;
        logic       w0;
        logic [3:0] c1;
        logic       t1;
        logic       w1;
    } exp_t;
    logic clk = 1'b0;
    logic r0, r1;
    logic [3:0] count0, count1;
    logic tc0, tc1, wrap0, wrap1;
    int n_checks = 0;
    int n_errors = 0;
    exp_t sb[$];
    logic [3:0] m_c0, m_c1;
    logic m_w0, m_w1;
    always #5 clk = ~clk;
    up_counter dut0 (.clk(clk), .reset(r0), .count(count0), .tc(tc0), .wrap(wrap0));
    up_counter #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3)) dut1 (
        .clk(clk), .reset(r1), .count(count1), .tc(tc1), .wrap(wrap1));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask
    task automatic push_model();
        exp_t e;
        e.c0 = m_c0; e.t0 = (m_c0 == 4'd15); e.w0 = m_w0;
        e.c1 = m_c1; e.t1 = (m_c1 == 4'd9);  e.w1 = m_w1;
        sb.push_back(e);
    endtask
    task automatic pop_compare();
        exp_t e;
        e = sb.pop_front();
        check("count0", 32'(count0), 32'(e.c0));
        check("tc0",    32'(tc0),    32'(e.t0));
        check("wrap0",  32'(wrap0),  32'(e.w0));
        check("count1", 32'(count1), 32'(e.c1));
        check("tc1",    32'(tc1),    32'(e.t1));
        check("wrap1",  32'(wrap1),  32'(e.w1));
    endtask
    task automatic model_async();
        if (r0) begin m_c0 = 4'd0; m_w0 = 1'b0; end
        if (r1) begin m_c1 = 4'd3; m_w1 = 1'b0; end
    endtask
    task automatic model_edge();
        if (r0) begin m_c0 = 4'd0; m_w0 = 1'b0; end
        else begin m_w0 = (m_c0 == 4'd15); m_c0 = m_w0 ? 4'd0 : m_c0 + 4'd1; end
        if (r1) begin m_c1 = 4'd3; m_w1 = 1'b0; end
        else begin m_w1 = (m_c1 == 4'd9); m_c1 = m_w1 ? 4'd0 : m_c1 + 4'd1; end
    endtask
    task automatic set_reset(input logic v0, input logic v1);
        r0 = v0;
        r1 = v1;
        model_async();
        push_model();
        #1 pop_compare();
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        push_model();
        #1 pop_compare();
        @(negedge clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        r0 = 1'b1;
        r1 = 1'b1;
        m_w0 = 1'b0;
        m_w1 = 1'b0;
        m_c0 = 4'd0;
        m_c1 = 4'd3;
        push_model();
        #1 pop_compare();
        @(negedge clk);
        set_reset(1'b0, 1'b0);
        repeat (10) tick();
        check("count_at_110ns", 32'(count0), 32'd10);
        repeat (20) tick();
        for (int i = 0; i < 16 && m_c0 != 4'd7; i++) tick();
        set_reset(1'b1, 1'b0);
        check("async_reset_count", 32'(count0), 32'd0);
        repeat (3) tick();
        set_reset(1'b0, 1'b0);
        repeat (3) tick();
        for (int i = 0; i < 16 && m_c0 != 4'd15; i++) tick();
        @(posedge clk);
        r0 = 1'b1;
        model_edge();
        push_model();
        #1 pop_compare();
        @(negedge clk);
        repeat (2) tick();
        set_reset(1'b0, 1'b0);
        repeat (3) tick();
        set_reset(1'b0, 1'b1);
        repeat (2) tick();
        set_reset(1'b0, 1'b0);
        repeat (1000) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
